// File: rtl/x_micro_sequencer_loader_pkg.sv
// Shared opcodes, FSM states and program-word layout for the micro-sequencer loader.
// X_MICRO_SEQUENCER_LOADER_CSUM_EN adds a per-word XOR checksum byte to WRITE frames.
package x_micro_sequencer_loader_pkg;

   localparam int unsigned WORD_BYTES = 5;
   localparam int unsigned WORD_W     = 8 * WORD_BYTES;
   localparam int unsigned ADDR_BYTES = 2;
   localparam int unsigned BYTE_IDX_W = 3;
   localparam int unsigned CMD_LSB    = 0;
   localparam int unsigned DATA_LSB   = 4;

   localparam logic [7:0] OP_SET_ADDR = 8'h01;
   localparam logic [7:0] OP_WRITE    = 8'h02;
   localparam logic [7:0] OP_START    = 8'h03;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      CSUM,
      WR,
      SWAIT,
      START
   } state_e;

   // XOR of all bytes of an assembled program word
   function automatic logic [7:0] word_xor(input logic [WORD_W-1:0] w);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
         x = x ^ w[8*i +: 8];
      end
      return x;
   endfunction

endpackage

// File: rtl/x_micro_sequencer_loader_shift.sv
// Little-endian byte assembler: writes each loaded byte at the current index and
// flags the last byte of a 2-byte (address) or WORD_BYTES-byte (data) frame.
module x_micro_sequencer_loader_shift
   import x_micro_sequencer_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic              two_byte,
   input  logic [7:0]        data_byte,
   output logic [WORD_W-1:0] word_nxt_c,
   output logic              last_c
);

   logic [WORD_W-1:0]     word;
   logic [BYTE_IDX_W-1:0] idx;
   logic [BYTE_IDX_W-1:0] limit;

   assign limit  = two_byte ? BYTE_IDX_W'(ADDR_BYTES) : BYTE_IDX_W'(WORD_BYTES);
   assign last_c = load && (idx == limit - BYTE_IDX_W'(1));

   // Word including the byte being accepted this cycle
   always_comb begin
      word_nxt_c = word;
      if (load) begin
         word_nxt_c[{idx, 3'b000} +: 8] = data_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         word <= '0;
         idx  <= '0;
      end else if (load) begin
         word <= word_nxt_c;
         idx  <= last_c ? '0 : idx + BYTE_IDX_W'(1);
      end
   end

endmodule

// File: rtl/x_micro_sequencer_loader.sv
// Byte-stream loader for x_micro_sequencer: decodes SET_ADDR/WRITE/START opcodes,
// drives the program RAM write port and the start pulse. Optional: X_MICRO_SEQUENCER_LOADER_CSUM_EN.
module x_micro_sequencer_loader
   import x_micro_sequencer_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 36,
   parameter int unsigned CMD_W  = 4
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [7:0]        i_byte,
   output logic              o_ready,
   input  logic              i_busy,
   output logic              o_start,
   output logic              o_wen,
   output logic [CMD_W-1:0]  o_wcmd,
   output logic [DATA_W-1:0] o_wdata,
   output logic [ADDR_W-1:0] o_waddr,
   output logic              o_err,
   output logic [ADDR_W:0]   o_wcount
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                ready_d, wen_d, start_d, err_d;
   logic [CMD_W-1:0]    wcmd_d;
   logic [DATA_W-1:0]   wdata_d;
   logic [ADDR_W-1:0]   waddr_d;
   logic [CNT_W-1:0]    wcount_d;
   logic                accept;
   logic                sh_clr, sh_load, sh_two, sh_last;
   logic [WORD_W-1:0]   sh_word_nxt;

   assign accept = i_valid && o_ready;
   assign sh_two = (state_q == ADDR);

   x_micro_sequencer_loader_shift u_shift (
      .clk        (i_clk),
      .rst        (i_rst),
      .clr        (sh_clr),
      .load       (sh_load),
      .two_byte   (sh_two),
      .data_byte  (i_byte),
      .word_nxt_c (sh_word_nxt),
      .last_c     (sh_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         o_ready  <= 1'b0;
         o_start  <= 1'b0;
         o_wen    <= 1'b0;
         o_wcmd   <= '0;
         o_wdata  <= '0;
         o_waddr  <= '0;
         o_err    <= 1'b0;
         o_wcount <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         o_ready  <= ready_d;
         o_start  <= start_d;
         o_wen    <= wen_d;
         o_wcmd   <= wcmd_d;
         o_wdata  <= wdata_d;
         o_waddr  <= waddr_d;
         o_err    <= err_d;
         o_wcount <= wcount_d;
      end
   end

   // Next state plus next values of the registered outputs
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      err_d    = o_err;
      wcount_d = o_wcount;
      wcmd_d   = o_wcmd;
      wdata_d  = o_wdata;
      waddr_d  = o_waddr;
      sh_clr   = 1'b0;
      sh_load  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sh_clr = 1'b1;
               case (i_byte)
                  OP_SET_ADDR: state_d = ADDR;
                  OP_WRITE:    state_d = DATA;
                  OP_START:    state_d = SWAIT;
                  default:     err_d   = 1'b1;
               endcase
            end
         end
         ADDR: begin
            if (accept) begin
               sh_load = 1'b1;
               if (sh_last) begin
                  ptr_d   = sh_word_nxt[ADDR_W-1:0];
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (accept) begin
               sh_load = 1'b1;
               if (sh_last) begin
`ifdef X_MICRO_SEQUENCER_LOADER_CSUM_EN
                  state_d = CSUM;
`else
                  state_d = WR;
`endif
               end
            end
         end
         CSUM: begin
`ifdef X_MICRO_SEQUENCER_LOADER_CSUM_EN
            if (accept) begin
               if (i_byte == word_xor(sh_word_nxt)) begin
                  state_d = WR;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
`else
            state_d = IDLE;
`endif
         end
         WR: begin
            state_d = IDLE;
            ptr_d   = ptr_q + ADDR_W'(1);
            if (o_wcount != CNT_MAX) begin
               wcount_d = o_wcount + CNT_W'(1);
            end
         end
         SWAIT: begin
            if (!i_busy) begin
               state_d = START;
            end
         end
         START: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Write fields are captured only on entry to WR and held afterwards
      if (state_d == WR && state_q != WR) begin
         wcmd_d  = sh_word_nxt[CMD_LSB +: CMD_W];
         wdata_d = sh_word_nxt[DATA_LSB +: DATA_W];
         waddr_d = ptr_q;
      end

      wen_d   = (state_d == WR);
      start_d = (state_d == START);
      ready_d = (state_d == IDLE) || (state_d == ADDR) ||
                (state_d == DATA) || (state_d == CSUM);
   end

endmodule

// File: tb/tb_x_micro_sequencer_loader.sv
// Directed self-checking bench for x_micro_sequencer_loader (default build and
// X_MICRO_SEQUENCER_LOADER_CSUM_EN build).
module tb_x_micro_sequencer_loader;

   logic        clk;
   logic        i_rst;
   logic        i_valid;
   logic [7:0]  i_byte;
   logic        o_ready;
   logic        i_busy;
   logic        o_start;
   logic        o_wen;
   logic [3:0]  o_wcmd;
   logic [35:0] o_wdata;
   logic [8:0]  o_waddr;
   logic        o_err;
   logic [9:0]  o_wcount;

   int n_checks = 0;
   int n_errors = 0;
   int wen_seen = 0;
   int start_seen = 0;

   x_micro_sequencer_loader dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .i_byte   (i_byte),
      .o_ready  (o_ready),
      .i_busy   (i_busy),
      .o_start  (o_start),
      .o_wen    (o_wen),
      .o_wcmd   (o_wcmd),
      .o_wdata  (o_wdata),
      .o_waddr  (o_waddr),
      .o_err    (o_err),
      .o_wcount (o_wcount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_wen)   wen_seen++;
      if (o_start) start_seen++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offer one byte and return just after the edge that accepted it
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      i_valid = 1'b1;
      i_byte  = b;
      while (!o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic write_word(input logic [39:0] w);
      logic [7:0] x;
      x = 8'h00;
      send_byte(8'h02);
      for (int i = 0; i < 5; i++) begin
         send_byte(w[8*i +: 8]);
         x = x ^ w[8*i +: 8];
      end
`ifdef X_MICRO_SEQUENCER_LOADER_CSUM_EN
      send_byte(x);
`endif
   endtask

   task automatic expect_write(input string tag, input logic [8:0] addr,
                               input logic [3:0] cmd, input logic [35:0] data);
      @(negedge clk);
      check({tag, "_wen"},   64'(o_wen),   64'd1);
      check({tag, "_waddr"}, 64'(o_waddr), 64'(addr));
      check({tag, "_wcmd"},  64'(o_wcmd),  64'(cmd));
      check({tag, "_wdata"}, 64'(o_wdata), 64'(data));
      check({tag, "_ready"}, 64'(o_ready), 64'd0);
      @(negedge clk);
      check({tag, "_wen_off"}, 64'(o_wen), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"},  64'(o_ready),  64'd0);
      check({tag, "_start"},  64'(o_start),  64'd0);
      check({tag, "_wen"},    64'(o_wen),    64'd0);
      check({tag, "_wcmd"},   64'(o_wcmd),   64'd0);
      check({tag, "_wdata"},  64'(o_wdata),  64'd0);
      check({tag, "_waddr"},  64'(o_waddr),  64'd0);
      check({tag, "_err"},    64'(o_err),    64'd0);
      check({tag, "_wcount"}, 64'(o_wcount), 64'd0);
   endtask

   initial begin
      int w0;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_byte  = 8'h00;
      i_busy  = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("rst");
      i_rst = 1'b0;
      @(negedge clk);
      check("rst_ready_after", 64'(o_ready), 64'd1);

      // First WRITE at pointer 0
      write_word(40'hCDEF12345A);
      expect_write("wr0", 9'd0, 4'hA, 36'hCDEF12345);
      check("wr0_wcount", 64'(o_wcount), 64'd1);
      check("wr0_ready_back", 64'(o_ready), 64'd1);

      // Pointer auto-increments
      write_word(40'h5544332211);
      expect_write("wr1", 9'd1, 4'h1, 36'h554433221);

      // SET_ADDR to 511, then wrap to 0
      send_byte(8'h01);
      send_byte(8'hFF);
      send_byte(8'h01);
      w0 = wen_seen;
      repeat (2) @(negedge clk);
      check("setaddr_no_wen", 64'(wen_seen), 64'(w0));
      write_word(40'h0123456789);
      expect_write("wr511", 9'd511, 4'h9, 36'h012345678);
      write_word(40'hFFFFFFFFF0);
      expect_write("wrwrap", 9'd0, 4'h0, 36'hFFFFFFFFF);
      check("wrwrap_wcount", 64'(o_wcount), 64'd4);
      check("wen_pulses", 64'(wen_seen), 64'd4);

      // START held off by busy
      i_busy = 1'b1;
      send_byte(8'h03);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("swait_ready", 64'(o_ready), 64'd0);
         check("swait_start", 64'(o_start), 64'd0);
      end
      i_busy = 1'b0;
      @(negedge clk);
      check("start_pulse", 64'(o_start), 64'd1);
      check("start_ready", 64'(o_ready), 64'd0);
      @(negedge clk);
      check("start_off", 64'(o_start), 64'd0);
      check("start_ready_back", 64'(o_ready), 64'd1);
      check("start_count", 64'(start_seen), 64'd1);

      // Illegal opcode sets sticky error; a following WRITE still lands
      w0 = wen_seen;
      send_byte(8'h7E);
      @(negedge clk);
      check("badop_err", 64'(o_err), 64'd1);
      check("badop_no_wen", 64'(wen_seen), 64'(w0));
      check("badop_ready", 64'(o_ready), 64'd1);
      write_word(40'h000000003C);
      expect_write("wr_after_err", 9'd1, 4'hC, 36'h000000003);
      check("err_sticky", 64'(o_err), 64'd1);
      check("wcount5", 64'(o_wcount), 64'd5);

      // Reset in the middle of a WRITE frame
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      check_reset_values("midrst");
      i_rst = 1'b0;
      @(negedge clk);
      write_word(40'hE5D4C3B2A1);
      expect_write("wr_fresh", 9'd0, 4'h1, 36'hE5D4C3B2A);
      check("wr_fresh_wcount", 64'(o_wcount), 64'd1);
      check("wr_fresh_err", 64'(o_err), 64'd0);

`ifdef X_MICRO_SEQUENCER_LOADER_CSUM_EN
      // Good checksum writes; bad checksum flags error without writing
      write_word(40'h8877665544);
      expect_write("csum_ok", 9'd1, 4'h4, 36'h887766554);
      check("csum_ok_wcount", 64'(o_wcount), 64'd2);
      w0 = wen_seen;
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h04);
      send_byte(8'h08);
      send_byte(8'h10);
      send_byte(8'h00);
      repeat (3) @(negedge clk);
      check("csum_bad_no_wen", 64'(wen_seen), 64'(w0));
      check("csum_bad_err", 64'(o_err), 64'd1);
      check("csum_bad_wcount", 64'(o_wcount), 64'd2);
      check("csum_bad_ready", 64'(o_ready), 64'd1);
      write_word(40'h0000000007);
      expect_write("csum_after_bad", 9'd2, 4'h7, 36'h000000000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/x_micro_sequencer_loader.md
Name: x_micro_sequencer_loader

Overview:
- Upstream stage for x_micro_sequencer.
- Takes a byte stream (UART or host bridge, valid/ready) and decodes a small opcode protocol.
- Assembles 40-bit program words ({data[35:0], cmd[3:0]}) and drives the sequencer's RAM write port with an auto-incrementing address.
- Issues a one-cycle start pulse once the sequencer reports not busy.

Parameters:
- ADDR_W, 9: sequencer RAM address width.
- DATA_W, 36: sequencer data width.
- CMD_W, 4: sequencer command width.
- WORD_BYTES, 5: bytes per program word, = ceil((DATA_W+CMD_W)/8); sized for the defaults.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input byte valid.
- i_byte  in  8  input byte.
- o_ready  out  1  loader accepts i_byte this cycle when i_valid&o_ready.
- i_busy  in  1  sequencer busy (from x_micro_sequencer o_busy).
- o_start  out  1  one-cycle start pulse to sequencer i_start.
- o_wen  out  1  RAM write enable.
- o_wcmd  out  CMD_W  write command field.
- o_wdata  out  DATA_W  write data field.
- o_waddr  out  ADDR_W  write address.
- o_err  out  1  sticky protocol error.
- o_wcount  out  ADDR_W+1  saturating count of words written since reset.

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: o_ready=0 in the reset cycle, then 1 (IDLE); o_start=0, o_wen=0, o_wcmd=0, o_wdata=0, o_waddr=0, o_err=0, o_wcount=0. Internal address pointer=0.
- Opcodes (shared package):
  - 0x01 SET_ADDR, followed by 2 bytes (little-endian); pointer = value[ADDR_W-1:0], upper bits ignored.
  - 0x02 WRITE, followed by WORD_BYTES bytes (little-endian 40-bit word); bits[3:0]=cmd, bits[39:4]=data.
  - 0x03 START.
  - Any other value: o_err<=1, byte consumed, stay in IDLE.
- States:
  - IDLE: accept opcode.
  - ADDR: collect 2 bytes, then IDLE.
  - DATA: collect WORD_BYTES bytes, then WR (or CSUM when the optional feature is enabled).
  - WR: o_wen=1 for exactly one cycle with the assembled fields and o_waddr=pointer. Pointer increments, wrapping 511->0. o_wcount increments, saturating at 2^ADDR_W. Then IDLE.
  - SWAIT: hold while i_busy=1; when i_busy=0, go to START.
  - START: o_start=1 for one cycle, then IDLE.
- o_ready: 1 in IDLE, ADDR and DATA (and CSUM); 0 in WR, SWAIT and START.
- A byte is consumed only on i_valid&o_ready. Idle gaps between bytes are allowed indefinitely; there is no timeout.
- Latency: the o_wen pulse occurs in the cycle after the last data byte is accepted. o_start occurs no earlier than 2 cycles after the START opcode is accepted (SWAIT is always entered for at least one cycle).
- o_wcmd, o_wdata and o_waddr hold their last written value outside WR.
- SET_ADDR arriving mid-program changes the pointer only; no write.
- i_busy toggling during SWAIT: START is taken on the first cycle i_busy is sampled 0.
- Reset mid-frame: partial bytes are discarded, state returns to IDLE, pointer=0, o_err cleared.
- o_err is cleared only by reset.

Optional Feature:
- Macro: X_MICRO_SEQUENCER_LOADER_CSUM_EN.
- Defined:
  - WRITE frame carries one extra byte equal to the XOR of the WORD_BYTES data bytes; state CSUM collects it.
  - Match: proceed to WR.
  - Mismatch: no write, pointer and o_wcount unchanged, o_err<=1, return to IDLE.
- Undefined: no checksum byte; DATA goes directly to WR.

Decomposition:
- Package x_micro_sequencer_loader_pkg holds:
  - opcode localparams OP_SET_ADDR, OP_WRITE, OP_START;
  - state enum (IDLE, ADDR, DATA, CSUM, WR, SWAIT, START);
  - WORD_BYTES and the field bit positions.
- Sub-module x_micro_sequencer_loader_shift: little-endian byte assembler with load/clear and a byte-index counter that flags the last byte. Used for both ADDR and DATA collection (width 40, 2-byte mode for address).

Test Plan:
- WRITE 0x02,0x5A,0x34,0x12,0xEF,0xCD with pointer 0 -> one o_wen cycle with o_wcmd=0xA, o_wdata=0xCDEF12345, o_waddr=0; then o_wcount=1 and pointer=1.
- SET_ADDR 0x01,0xFF,0x01 then two WRITEs -> writes at o_waddr=511 then 0 (wrap); o_wcount=2.
- START 0x03 with i_busy=1 for 10 cycles -> o_ready=0 throughout, o_start low. i_busy drops -> o_start high for exactly 1 cycle the next cycle, then o_ready=1.
- Opcode 0x7E -> o_err=1, no o_wen. A following valid WRITE still completes; o_err stays 1 until i_rst.
- i_rst asserted after 3 of 5 WRITE data bytes -> next cycle all outputs are at reset values. A fresh WRITE writes to address 0 with only the new bytes.
- With X_MICRO_SEQUENCER_LOADER_CSUM_EN: correct XOR byte -> write occurs. Wrong XOR byte -> no o_wen, o_err=1, o_wcount unchanged.
